bcd_countdown: RTL and testbench
================================

Name: bcd_countdown

Overview:
Loadable two-digit BCD down-counter: the countdown companion to the team's 01..99 BCD up-counter, sharing the same digit-pair output format for the HEX display path.
Software/switch logic loads a start value and issues start/pause commands. The block decrements once per prescaled tick down to 00, then emits a one-cycle done pulse.
Optional auto-reload turns it into a repeating interval timer.

Parameters:
TICK_DIV, 1, clock cycles per decrement (≥1; width of prescaler = clog2(TICK_DIV), min 1 bit)
AUTO_RELOAD, 0, 1 = on reaching 00 reload last loaded value and keep running

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
load  input  1  capture load_msb/load_lsb into counter and reload register
load_lsb  input  4  BCD ones digit to load
load_msb  input  4  BCD tens digit to load
start  input  1  begin or resume counting
pause  input  1  suspend counting
countLSB  output  4  current ones digit (BCD 0-9)
countMSB  output  4  current tens digit (BCD 0-9)
running  output  1  high while in RUN
done  output  1  one-cycle pulse when count reaches 00

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset values: countLSB=0, countMSB=0, reload reg=00, prescaler=0, state=IDLE, running=0, done=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Command priority each edge: load > pause > start.
- load, in any state:
  - Next edge: count and reload reg take the load digits, prescaler=0, state→IDLE, done=0.
  - Any digit >9 is clamped to 9 (e.g. 4'hC → 9).
- IDLE:
  - start with count≠00 → RUN, prescaler=0.
  - start with count=00 → ignored, stay IDLE.
- RUN:
  - running=1. Prescaler increments each cycle; when it equals TICK_DIV-1 it clears and a decrement occurs on the same edge.
  - The first decrement happens TICK_DIV cycles after the edge that entered RUN.
- Decrement rule:
  - LSB≠0 → LSB-1.
  - LSB=0 → LSB=9 and MSB-1.
  - Never decrements from 00.
- Reaching 00 (the decrement result is 00):
  - AUTO_RELOAD=0: count shows 00, state→DONE, done=1 for exactly that cycle, running=0.
  - AUTO_RELOAD=1: count loads the reload reg instead of 00, stays RUN, done pulses 1 cycle.
  - AUTO_RELOAD=1 with reload reg=00: behaves as AUTO_RELOAD=0.
- pause in RUN → PAUSE next edge. The prescaler value is held, so no tick is lost or duplicated on resume.
- PAUSE: start → RUN with the prescaler continuing from its held value; pause+start together → stay PAUSE.
- DONE: lasts one cycle, then → IDLE with done=0. A load or reset in DONE takes priority.
- Count stays 00 in IDLE after done until the next load.
- pause in IDLE/DONE: no effect.
- Reset mid-RUN: immediate return to reset values. The reload value is lost.
- Outputs are always valid BCD (0-9); no state produces a value 10-15.

Decomposition:
- Shared package counter_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD_MAX=4'd9
  - BCD digit width constant 4
- One natural sub-module, bcd_digit_down: one BCD digit with decrement-enable in, borrow out, and clamp-on-load. Two instances are chained (LSB borrow enables MSB).
- The prescaler and FSM stay inline.

Test Plan:
- Reset: assert reset_n=0 mid-RUN at count 37 → countMSB/LSB=0/0, running=0, done=0 immediately, without waiting for a clock edge.
- TICK_DIV=1: load 12, start → 11,10,09,...,01,00 on successive cycles; done high exactly one cycle coincident with 00; then IDLE, count held at 00.
- TICK_DIV=4: load 03, start, pause after 6 cycles for 10 cycles, then start → count 03→02 at cycle 4, holds 02 during pause, 01 at 2 cycles after resume, 00 4 cycles later.
- Boundaries:
  - load A5 (4'hA,4'h5) → 95.
  - load 00 + start → stays IDLE, no done.
  - load and start same cycle → load wins, IDLE.
- AUTO_RELOAD=1, TICK_DIV=1: load 02, start → 01,02,01,02... with done pulse at each reload; pause+start together in PAUSE → remains paused.
- Borrow: load 10, start → 09 (LSB wraps to 9, MSB 1→0), then 08.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the BCD counter family: FSM states, digit width and the
// clamp helper used when external digits are captured.
package counter_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Values 10..15 are not BCD; saturate them to 9 so every stored digit stays legal.
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down 9..0 with wrap, a borrow out for chaining to the
// next more-significant digit, and a clamped parallel load that wins over decrement.
module bcd_digit_down
    import counter_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec,
    output logic             borrow,
    output logic [BCD_W-1:0] digit
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    // Borrow asserts when a decrement wraps this digit from 0 to 9.
    assign borrow = dec && (digit_q == '0);
    assign digit  = digit_q;

    // Next digit value: load beats decrement, decrement wraps 0 -> 9.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = clamp_bcd(load_val);
        end else if (dec) begin
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
        end
    end

    // Digit register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Loadable two-digit BCD down-counter with prescaled ticks, pause/resume, a one-cycle
// done pulse on reaching 00 and optional auto-reload for repeating intervals.
module bcd_countdown
    import counter_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BCD_W-1:0] load_lsb,
    input  logic [BCD_W-1:0] load_msb,
    input  logic             start,
    input  logic             pause,
    output logic [BCD_W-1:0] countLSB,
    output logic [BCD_W-1:0] countMSB,
    output logic             running,
    output logic             done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_e           state_q;
    state_e           state_d;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic [BCD_W-1:0] rel_lsb_q;
    logic [BCD_W-1:0] rel_msb_q;
    logic             done_q;
    logic             done_d;
    logic             running_q;

    logic [BCD_W-1:0] lsb;
    logic [BCD_W-1:0] msb;
    logic             lsb_borrow;
    logic             msb_borrow;
    logic             count_zero;
    logic             at_one;
    logic             reload_en;
    logic             tick;
    logic             reload_hit;
    logic             dig_load;
    logic             dec_en;
    logic [BCD_W-1:0] dig_lsb_val;
    logic [BCD_W-1:0] dig_msb_val;

    assign count_zero = (msb == '0) && (lsb == '0);
    // A tick while at 01 is the one that reaches 00.
    assign at_one     = (msb == '0) && (lsb == 4'd1);
    // A zero reload value would just re-trigger done forever, so treat it as one-shot.
    assign reload_en  = (AUTO_RELOAD != 0) && ((rel_msb_q != '0) || (rel_lsb_q != '0));

    // FSM next state, prescaler and tick generation; load > pause > start.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        tick    = 1'b0;
        if (load) begin
            state_d = StIdle;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !count_zero) begin
                        state_d = StRun;
                        pre_d   = '0;
                    end
                end
                StRun: begin
                    if (pause) begin
                        // Prescaler is held so resume neither loses nor repeats a tick.
                        state_d = StPause;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (!count_zero) begin
                            tick = 1'b1;
                            if (at_one) begin
                                done_d = 1'b1;
                                if (!reload_en) begin
                                    state_d = StDone;
                                end
                            end
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                StPause: begin
                    if (start && !pause) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Digit load/decrement steering: external load, else reload on wrap-to-zero, else tick.
    always_comb begin
        reload_hit  = tick && at_one && reload_en;
        dig_load    = load || reload_hit;
        dec_en      = tick && !reload_hit;
        dig_lsb_val = load ? load_lsb : rel_lsb_q;
        dig_msb_val = load ? load_msb : rel_msb_q;
    end

    bcd_digit_down u_lsb (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (dig_load),
        .load_val (dig_lsb_val),
        .dec      (dec_en),
        .borrow   (lsb_borrow),
        .digit    (lsb)
    );

    bcd_digit_down u_msb (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (dig_load),
        .load_val (dig_msb_val),
        .dec      (lsb_borrow),
        .borrow   (msb_borrow),
        .digit    (msb)
    );

    // State, prescaler, reload value and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            rel_lsb_q <= '0;
            rel_msb_q <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            done_q    <= done_d;
            running_q <= (state_d == StRun);
            if (load) begin
                rel_lsb_q <= clamp_bcd(load_lsb);
                rel_msb_q <= clamp_bcd(load_msb);
            end
        end
    end

    assign countLSB = lsb;
    assign countMSB = msb;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench: three parameterisations share one stimulus stream and are checked every cycle
// against an integer-valued model, plus hand-computed directed expectations.
module tb_bcd_countdown;

    localparam int N = 3;
    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MP = 2;
    localparam int MD = 3;

    int td [N] = '{1, 4, 1};
    int ar [N] = '{0, 0, 1};

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_lsb = 4'd0;
    logic [3:0] load_msb = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [3:0] o_lsb  [N];
    logic [3:0] o_msb  [N];
    logic       o_run  [N];
    logic       o_done [N];

    int  m_cnt  [N];
    int  m_rel  [N];
    int  m_pre  [N];
    int  m_st   [N];
    bit  m_done [N];

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    bcd_countdown #(.TICK_DIV(1), .AUTO_RELOAD(0)) u_td1 (
        .clock(clock), .reset_n(reset_n), .load(load), .load_lsb(load_lsb),
        .load_msb(load_msb), .start(start), .pause(pause), .countLSB(o_lsb[0]),
        .countMSB(o_msb[0]), .running(o_run[0]), .done(o_done[0])
    );

    bcd_countdown #(.TICK_DIV(4), .AUTO_RELOAD(0)) u_td4 (
        .clock(clock), .reset_n(reset_n), .load(load), .load_lsb(load_lsb),
        .load_msb(load_msb), .start(start), .pause(pause), .countLSB(o_lsb[1]),
        .countMSB(o_msb[1]), .running(o_run[1]), .done(o_done[1])
    );

    bcd_countdown #(.TICK_DIV(1), .AUTO_RELOAD(1)) u_ar1 (
        .clock(clock), .reset_n(reset_n), .load(load), .load_lsb(load_lsb),
        .load_msb(load_msb), .start(start), .pause(pause), .countLSB(o_lsb[2]),
        .countMSB(o_msb[2]), .running(o_run[2]), .done(o_done[2])
    );

    function automatic int clamp9(input logic [3:0] d);
        return (int'(d) > 9) ? 9 : int'(d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_pre[i] = 0; m_st[i] = MI; m_done[i] = 0;
        end
    endtask

    // Count held as a plain integer 0..99; one tick = subtract one.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            m_done[i] = 0;
            if (load) begin
                m_cnt[i] = 10 * clamp9(load_msb) + clamp9(load_lsb);
                m_rel[i] = m_cnt[i];
                m_pre[i] = 0;
                m_st[i]  = MI;
            end else begin
                case (m_st[i])
                    MI: if (start && m_cnt[i] != 0) begin m_st[i] = MR; m_pre[i] = 0; end
                    MR: begin
                        if (pause) m_st[i] = MP;
                        else begin
                            m_pre[i] = m_pre[i] + 1;
                            if (m_pre[i] == td[i]) begin
                                m_pre[i] = 0;
                                m_cnt[i] = m_cnt[i] - 1;
                                if (m_cnt[i] == 0) begin
                                    m_done[i] = 1;
                                    if (ar[i] != 0 && m_rel[i] != 0) m_cnt[i] = m_rel[i];
                                    else m_st[i] = MD;
                                end
                            end
                        end
                    end
                    MP: if (start && !pause) m_st[i] = MR;
                    default: m_st[i] = MI;
                endcase
            end
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    function automatic int pack(input int run, input int dn, input int msb, input int lsb);
        return run * 100000 + dn * 10000 + msb * 100 + lsb;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int i);
        return int'(o_msb[i]) * 10 + int'(o_lsb[i]);
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("cycle inst%0d", i),
                pack(int'(o_run[i]), int'(o_done[i]), int'(o_msb[i]), int'(o_lsb[i])),
                pack((m_st[i] == MR) ? 1 : 0, int'(m_done[i]), m_cnt[i] / 10, m_cnt[i] % 10));
        end
    end

    task automatic step(input logic ld, input logic [3:0] lm, input logic [3:0] ll,
                        input logic st, input logic pa);
        load = ld; load_msb = lm; load_lsb = ll; start = st; pause = pa;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12 reset_n = 1'b1;
        @(negedge clock);
        chk("reset count", cnt_of(0), 0);
        chk("reset running", int'(o_run[0]), 0);

        // Clamp and load boundaries.
        step(1'b1, 4'hA, 4'h5, 1'b0, 1'b0);
        chk("load A5 clamp", cnt_of(0), 95);
        chk("load A5 clamp td4", cnt_of(1), 95);
        step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("start at 00 running", int'(o_run[0]), 0);
        chk("start at 00 done", int'(o_done[0]), 0);
        step(1'b1, 4'd5, 4'd3, 1'b1, 1'b0);
        chk("load beats start running", int'(o_run[0]), 0);
        chk("load beats start count", cnt_of(0), 53);

        // TICK_DIV=1 full countdown from 12, including the 10 -> 09 borrow.
        step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("td1 start running", int'(o_run[0]), 1);
        chk("td1 start count", cnt_of(0), 12);
        for (int v = 11; v >= 0; v--) begin
            idle(1);
            chk("td1 count", cnt_of(0), v);
            chk("td1 done", int'(o_done[0]), (v == 0) ? 1 : 0);
        end
        chk("td1 stopped", int'(o_run[0]), 0);
        idle(1);
        chk("td1 done cleared", int'(o_done[0]), 0);
        chk("td1 held 00", cnt_of(0), 0);

        // TICK_DIV=4 with a pause in the middle.
        step(1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(3);
        chk("td4 before first tick", cnt_of(1), 3);
        idle(1);
        chk("td4 first tick", cnt_of(1), 2);
        idle(2);
        for (int k = 0; k < 10; k++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        chk("td4 paused count", cnt_of(1), 2);
        chk("td4 paused running", int'(o_run[1]), 0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("td4 resumed", int'(o_run[1]), 1);
        idle(1);
        chk("td4 resume +1", cnt_of(1), 2);
        idle(1);
        chk("td4 resume +2", cnt_of(1), 1);
        idle(3);
        chk("td4 hold at 01", cnt_of(1), 1);
        idle(1);
        chk("td4 reach 00", cnt_of(1), 0);
        chk("td4 done", int'(o_done[1]), 1);

        // AUTO_RELOAD interval timer from 02.
        step(1'b1, 4'd0, 4'd2, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        chk("ar 01", cnt_of(2), 1);
        idle(1);
        chk("ar reload 02", cnt_of(2), 2);
        chk("ar done pulse", int'(o_done[2]), 1);
        chk("ar still running", int'(o_run[2]), 1);
        idle(1);
        chk("ar 01 again", cnt_of(2), 1);
        chk("ar done low", int'(o_done[2]), 0);
        idle(1);
        chk("ar done again", int'(o_done[2]), 1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        chk("ar paused", int'(o_run[2]), 0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        chk("ar pause+start stays", int'(o_run[2]), 0);
        chk("ar pause+start count", cnt_of(2), 2);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("ar resumed", int'(o_run[2]), 1);

        // Asynchronous reset mid-run at 37.
        step(1'b1, 4'd3, 4'd7, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        chk("pre-reset 37", cnt_of(1), 37);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("async reset", pack(int'(o_run[i]), int'(o_done[i]), int'(o_msb[i]),
                int'(o_lsb[i])), 0);
        end
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // Random traffic; start and pause kept exclusive, the joint case is directed above.
        for (int n = 0; n < 3000; n++) begin
            logic       ld;
            logic       st;
            logic       pa;
            logic [3:0] lm;
            logic [3:0] ll;
            ld = ($urandom % 12) == 0;
            lm = 4'($urandom);
            ll = 4'($urandom);
            if ($urandom % 2 == 1) lm = 4'($urandom % 3);
            st = ($urandom % 5) == 0;
            pa = !st && (($urandom % 9) == 0);
            step(ld, lm, ll, st, pa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
